// File: rtl/cs_resolve_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : cs_resolve_adder_if
// Purpose  : Handshake bundle for the carry/sum resolve stage. It carries the
//            upstream sum/carry pair and the downstream product, each with a
//            valid/ready pair.
// Revision : 1.0  initial release
// ============================================================================
interface cs_resolve_adder_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] carry;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] product;

    // The driver of the sum/carry pair, which also consumes the product.
    modport master (
        output in_valid, sum, carry, out_ready,
        input  in_ready, out_valid, product
    );

    // The resolve adder itself.
    modport slave (
        input  in_valid, sum, carry, out_ready,
        output in_ready, out_valid, product
    );
endinterface
`default_nettype wire

// File: rtl/cs_resolve_adder.sv
`default_nettype none
// ============================================================================
// Module   : cs_resolve_adder
// Purpose  : Final carry-propagate stage of the Booth multiplier. It resolves
//            the redundant sum/carry pair into a binary product using two
//            pipeline stages with a split carry. Stage 1 adds the low slice
//            and registers its carry-out. Stage 2 adds the high slice with
//            that carry-in.
// Revision : 1.0  initial release
// ============================================================================
module cs_resolve_adder #(
    parameter int DATA_WIDTH = 16,
    parameter int LOW_WIDTH  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    cs_resolve_adder_if.slave  bus
);
    localparam int c_HI_WIDTH = DATA_WIDTH - LOW_WIDTH;

    // Carry vector aligned to its true weight. Bit DATA_WIDTH-1 of the
    // incoming carry falls off the top, which is the intended wrap.
    logic [DATA_WIDTH-1:0] w_carry_sh;
    logic [LOW_WIDTH:0]    w_lo_sum;
    logic [c_HI_WIDTH-1:0] w_hi_sum;
    logic                  w_unused_carry_msb;

    logic                  w_s2_free;
    logic                  w_s1_adv;
    logic                  w_in_ready;
    logic                  w_in_xfer;
    logic                  w_out_xfer;

    logic                  r_s1_valid;
    logic [LOW_WIDTH-1:0]  r_s1_lo;
    logic                  r_s1_c;
    logic [c_HI_WIDTH-1:0] r_s1_hi_a;
    logic [c_HI_WIDTH-1:0] r_s1_hi_b;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_product;

    assign w_carry_sh         = {bus.carry[DATA_WIDTH-2:0], 1'b0};
    assign w_unused_carry_msb = bus.carry[DATA_WIDTH-1];

    // Low slice add. The extra top bit is the carry into stage 2.
    assign w_lo_sum = {1'b0, bus.sum[LOW_WIDTH-1:0]}
                    + {1'b0, w_carry_sh[LOW_WIDTH-1:0]};

    // High slice add. The carry out of the MSB is dropped by the width.
    assign w_hi_sum = r_s1_hi_a + r_s1_hi_b + c_HI_WIDTH'(r_s1_c);

    // Stall pipeline control. Only out_ready reaches in_ready combinationally.
    assign w_s2_free  = !r_out_valid || bus.out_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_free;
    assign w_in_ready = (!r_s1_valid || w_s1_adv) && rst_n;
    assign w_in_xfer  = bus.in_valid && w_in_ready;
    assign w_out_xfer = r_out_valid && bus.out_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.product   = r_product;

    // Stage 1: capture the low-slice result and the raw high-slice operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_lo    <= '0;
            r_s1_c     <= 1'b0;
            r_s1_hi_a  <= '0;
            r_s1_hi_b  <= '0;
        end else begin
            if (w_in_xfer) begin
                r_s1_valid <= 1'b1;
                r_s1_lo    <= w_lo_sum[LOW_WIDTH-1:0];
                r_s1_c     <= w_lo_sum[LOW_WIDTH];
                r_s1_hi_a  <= bus.sum[DATA_WIDTH-1:LOW_WIDTH];
                r_s1_hi_b  <= w_carry_sh[DATA_WIDTH-1:LOW_WIDTH];
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2: the output register. It holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_product   <= '0;
        end else begin
            if (w_s1_adv) begin
                r_out_valid <= 1'b1;
                r_product   <= {w_hi_sum, r_s1_lo};
            end else if (w_out_xfer) begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cs_resolve_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cs_resolve_adder
// Purpose  : Self-checking bench for cs_resolve_adder. It applies directed and
//            random pairs. Expected products come from a plain-arithmetic
//            reference and are queued in order.
// Revision : 1.0  initial release
// ============================================================================
module tb_cs_resolve_adder;
    localparam int DW = 16;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    cs_resolve_adder_if #(.DATA_WIDTH(DW)) bus ();

    cs_resolve_adder #(.DATA_WIDTH(DW), .LOW_WIDTH(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10-unit clock with rising edges at 5, 15, 25 and so on.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_out = 0;
    int first_out_cyc = 0;
    int last_out_cyc = 0;
    logic [DW-1:0] last_prod = '0;
    logic [DW-1:0] q[$];

    // Reference: the full-width sum plus the doubled carry, reduced mod 2^DW.
    function automatic logic [DW-1:0] ref_fn(input logic [DW-1:0] s, input logic [DW-1:0] c);
        logic [31:0] t;
        t = 32'(s) + (32'(c) << 1);
        return t[DW-1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle. The task samples the handshakes just before the edge.
    // It compares output transfers against the queue and pushes accepted
    // inputs onto it. It returns 1 unit after the rising edge.
    task automatic tick();
        logic acc;
        logic otx;
        logic [DW-1:0] e;
        #2;
        acc = bus.in_valid & bus.in_ready;
        otx = bus.out_valid & bus.out_ready;
        if (otx) begin
            n_out++;
            if (n_out == 1) first_out_cyc = cyc;
            last_out_cyc = cyc;
            last_prod = bus.product;
            check("model_nonempty", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("product_vs_model", bus.product, e);
            end
        end
        if (acc) q.push_back(ref_fn(bus.sum, bus.carry));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Send one pair with an idle consumer downstream. Checks the two-stage
    // latency and the constant product value.
    task automatic send_one(input string tag, input logic [DW-1:0] s,
                            input logic [DW-1:0] c, input logic [DW-1:0] exp);
        bus.sum = s;
        bus.carry = c;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.sum = '0;
        bus.carry = '0;
        check({tag, "_ov_early"}, bus.out_valid, 1'b0);
        tick();
        check({tag, "_ov"}, bus.out_valid, 1'b1);
        check({tag, "_product"}, bus.product, exp);
        tick();
        check({tag, "_ov_drop"}, bus.out_valid, 1'b0);
    endtask

    initial begin
        int base;
        bus.in_valid = 1'b0;
        bus.sum = '0;
        bus.carry = '0;
        bus.out_ready = 1'b0;

        // Reset state.
        #1;
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_product", bus.product, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1'b1);

        // Directed arithmetic cases.
        send_one("basic", 16'h1234, 16'h0000, 16'h1234);
        send_one("cross1", 16'h00FF, 16'h0001, 16'h0101);
        send_one("cross2", 16'h00FE, 16'h0001, 16'h0100);
        send_one("wrap", 16'hFFFF, 16'h8001, 16'h0001);

        // Back-to-back random stream.
        n_out = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.sum = DW'($urandom);
            bus.carry = DW'($urandom);
            bus.in_valid = 1'b1;
            check("stream_in_ready", bus.in_ready, 1'b1);
            tick();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 12 && q.size() > 0; i++) tick();
        check("stream_count", n_out, 8);
        check("stream_contiguous", last_out_cyc - first_out_cyc, 7);
        check("stream_drained", q.size(), 0);

        // Backpressure with a two-entry capacity.
        base = n_out;
        bus.out_ready = 1'b0;
        bus.carry = '0;
        bus.in_valid = 1'b1;
        bus.sum = 16'h0001;
        tick();
        bus.sum = 16'h0002;
        tick();
        bus.sum = 16'h0003;
        check("bp_full_in_ready", bus.in_ready, 1'b0);
        tick();
        check("bp_stall_in_ready", bus.in_ready, 1'b0);
        check("bp_stall_ov", bus.out_valid, 1'b1);
        check("bp_hold_product", bus.product, 16'h0001);
        tick();
        check("bp_hold_product2", bus.product, 16'h0001);
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_c_accepted", q.size(), 2);
        check("bp_second_product", bus.product, 16'h0002);
        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        check("bp_out_count", n_out - base, 3);
        check("bp_last_product", last_prod, 16'h0003);

        // Reset while two entries are in flight.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.sum = 16'h0010;
        tick();
        bus.sum = 16'h0011;
        tick();
        bus.in_valid = 1'b0;
        check("mid_ov_before", bus.out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ov", bus.out_valid, 1'b0);
        check("mid_rst_product", bus.product, '0);
        check("mid_rst_in_ready", bus.in_ready, 1'b0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        n_out = 0;
        bus.sum = 16'h0042;
        bus.carry = 16'h0000;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.sum = '0;
        repeat (6) tick();
        check("mid_post_count", n_out, 1);
        check("mid_post_product", last_prod, 16'h0042);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
